m_timer_controller: RTL and testbench
=====================================

# m_timer_controller

Control stage for the kitchen timer. It sits directly upstream of the up/down digit-counter chain and drives that chain's `mode`, `clken` and carry/borrow-in strobes. It debounces the three front-panel buttons, generates the 1 Hz countdown tick, sequences SET/RUN/PAUSE/ALARM, and raises the buzzer when the chain reaches zero.

## Interface
Parameters:
- `DIV`, 50000000: clock cycles per countdown tick (1 Hz at 50 MHz); ≥2.
- `DEBOUNCE`, 500000: cycles a synchronized button level must be stable before acceptance; ≥1.
- `ALARM_TICKS`, 10: ticks the buzzer stays on before auto-return to SET; ≥1.

Ports:
- `clk`  in  1  system clock, all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_min`  in  1  raw minute button, active-high, asynchronous.
- `btn_sec`  in  1  raw second button, active-high, asynchronous.
- `btn_start`  in  1  raw start/stop button, active-high, asynchronous.
- `cnt_zero`  in  1  high when every digit of the counter chain is 0.
- `mode`  out  1  0 = up/set, 1 = down/run; to counter chain.
- `clken`  out  1  count-down enable to counter chain.
- `min_inc`  out  1  one-cycle strobe into the minutes-digit carry input.
- `sec_inc`  out  1  one-cycle strobe into the seconds-digit carry/borrow input.
- `buzzer`  out  1  alarm drive.
- `running`  out  1  high in RUN.

## Operation
- Button path, per button: 2-flop synchronizer, then stability counter. The accepted level updates after `DEBOUNCE` consecutive cycles of an unchanged synchronized level. A rising edge of the accepted level yields one internal press pulse of one cycle.
- Press priority in the same cycle: start > min > sec. Lower-priority presses are discarded.
- Prescaler: counts 0..DIV-1 and emits `tick` in the cycle count == DIV-1, then wraps to 0. It is held at 0 outside RUN and ALARM. It is cleared to 0 on every entry to RUN or ALARM.
- FSM states: SET (reset state), RUN, PAUSE, ALARM.
  - SET: `mode`=0, `clken`=0. A min press gives a `min_inc` pulse; a sec press gives a `sec_inc` pulse. Start with `cnt_zero`=0 goes to RUN. Start with `cnt_zero`=1 is ignored.
  - RUN: `mode`=1, `clken`=1, `running`=1.
    - `cnt_zero`=1 goes to ALARM; `sec_inc` is suppressed that cycle.
    - Otherwise a start press goes to PAUSE. It takes precedence over a coincident tick; no `sec_inc` is issued.
    - Otherwise a tick gives a `sec_inc` pulse.
    - Min/sec presses are ignored.
  - PAUSE: `mode`=1, `clken`=0. Start goes to RUN. A min or sec press goes to SET; that press is consumed and does not increment.
  - ALARM: `mode`=1, `clken`=0, `buzzer`=1. An alarm tick counter counts ticks. After `ALARM_TICKS` ticks, go to SET. Any press goes to SET immediately; it is consumed.
- All outputs are registered and change one cycle after the state or event that causes them.
- Reset (any time, including mid-RUN or mid-ALARM):
  - state returns to SET;
  - prescaler, alarm counter, debounce counters and synchronizers are cleared;
  - accepted button levels are cleared to 0, so a button held through reset produces no press;
  - outputs `mode`=0, `clken`=0, `min_inc`=0, `sec_inc`=0, `buzzer`=0, `running`=0.

## Timing
- Button latency: raw edge → press pulse at most 2 + `DEBOUNCE` + 1 cycles. Glitches shorter than `DEBOUNCE` cycles produce nothing.
- Press → strobe or state-output change: 1 cycle.
- First `sec_inc` after entering RUN: `DIV` cycles after entry. Subsequent strobes come every `DIV` cycles.
- `cnt_zero` rising in RUN → `buzzer`=1 after 1 cycle.
- ALARM duration without a press: exactly `ALARM_TICKS`×`DIV` cycles, then `buzzer`=0 in the following cycle.
- Strobes are never wider than one cycle. `min_inc` and `sec_inc` are never high in the same cycle.

## Test plan
Bench parameters: DIV=10, DEBOUNCE=4, ALARM_TICKS=3.

- Reset and glitch rejection: assert `rst_n`=0 mid-run → all outputs 0 and state SET. Pulse `btn_min` for 3 cycles → no `min_inc`.
- Set phase: 2 clean sec presses, then 1 min press, in SET → exactly 2 `sec_inc` pulses and 1 `min_inc` pulse, each 1 cycle wide, with `mode`=0.
- Countdown and alarm: start with `cnt_zero`=0 → `mode`=1 and `clken`=1. `sec_inc` fires at 10, 20, 30 cycles after entry. Raise `cnt_zero` → no further `sec_inc`, and `buzzer`=1 next cycle. After 30 cycles `buzzer`=0 and `mode`=0.
- Pause and resume: start in RUN → `clken`=0 and no `sec_inc`. Start again → next `sec_inc` exactly 10 cycles after re-entry. A sec press in PAUSE → SET with no `sec_inc`.
- Priorities and edge cases:
  - start and min pressed together in SET → RUN, no `min_inc`;
  - start press coinciding with a tick in RUN → PAUSE, no `sec_inc`;
  - start in SET with `cnt_zero`=1 → stays in SET.
- Alarm abort: any press during ALARM → `buzzer`=0 next cycle, state SET, no strobe.

Source files
------------

// File: rtl/m_timer_controller_if.sv
// Front-panel and counter-chain signals of the kitchen-timer control stage.
// The master side drives the buttons and cnt_zero; the slave side is the controller.
interface m_timer_controller_if;
  logic btn_min;
  logic btn_sec;
  logic btn_start;
  logic cnt_zero;
  logic mode;
  logic clken;
  logic min_inc;
  logic sec_inc;
  logic buzzer;
  logic running;

  modport master (
    output btn_min, btn_sec, btn_start, cnt_zero,
    input  mode, clken, min_inc, sec_inc, buzzer, running
  );

  modport slave (
    input  btn_min, btn_sec, btn_start, cnt_zero,
    output mode, clken, min_inc, sec_inc, buzzer, running
  );
endinterface

// File: rtl/m_timer_controller.sv
// Kitchen-timer control stage: button debounce, 1 Hz prescaler, and the
// SET/RUN/PAUSE/ALARM sequencer that drives the up/down digit-counter chain.
module m_timer_controller #(
  parameter int unsigned DIV         = 50000000,
  parameter int unsigned DEBOUNCE    = 500000,
  parameter int unsigned ALARM_TICKS = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  m_timer_controller_if.slave bus
);
  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  typedef enum logic [1:0] {ST_SET, ST_RUN, ST_PAUSE, ST_ALARM} state_e;

  // Button vectors: bit 0 = sec, bit 1 = min, bit 2 = start.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    level_q, level_d;
  logic [2:0]    arm_q, arm_d;
  logic [2:0]    press_q, press_d;
  logic [DW-1:0] db_cnt_q [3];
  logic [DW-1:0] db_cnt_d [3];
  logic [1:0]    prime_q;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          tick;
  logic          min_inc_d, sec_inc_d;

  logic mode_q, clken_q, min_inc_q, sec_inc_q, buzzer_q, running_q;

  assign btn_raw = {bus.btn_start, bus.btn_min, bus.btn_sec};
  assign tick    = (pre_q == PW'(DIV - 1));

  // Two-flop synchronizers plus a fill marker showing when sync2 holds real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prime_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  // Stability counters and press detection. A button only arms once it has
  // been seen released after reset, so a button held through reset never
  // yields a press even though its accepted level rises.
  always_comb begin
    level_d = level_q;
    arm_d   = arm_q;
    press_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE - 1)) begin
          level_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i] & arm_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
      if (prime_q[1] && !sync2_q[i] && !level_q[i]) begin
        arm_d[i] = 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      arm_q   <= '0;
      press_q <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      arm_q   <= arm_d;
      press_q <= press_d;
      for (int unsigned i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Sequencer next state and strobes; else-if order gives start > min > sec.
  always_comb begin
    state_d   = state_q;
    min_inc_d = 1'b0;
    sec_inc_d = 1'b0;
    unique case (state_q)
      ST_SET: begin
        if (press_q[2]) begin
          if (!bus.cnt_zero) state_d = ST_RUN;
        end else if (press_q[1]) begin
          min_inc_d = 1'b1;
        end else if (press_q[0]) begin
          sec_inc_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.cnt_zero) begin
          state_d = ST_ALARM;
        end else if (press_q[2]) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          sec_inc_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (press_q[2]) begin
          state_d = ST_RUN;
        end else if (press_q[1] || press_q[0]) begin
          state_d = ST_SET;
        end
      end
      ST_ALARM: begin
        if (press_q != 3'b000) begin
          state_d = ST_SET;
        end else if (tick && (acnt_q == AW'(ALARM_TICKS - 1))) begin
          state_d = ST_SET;
        end
      end
      default: state_d = ST_SET;
    endcase
  end

  // Prescaler and alarm tick count: zero outside RUN/ALARM and on any state change.
  always_comb begin
    pre_d  = '0;
    acnt_d = '0;
    if ((state_d == state_q) && ((state_q == ST_RUN) || (state_q == ST_ALARM))) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (state_q == ST_ALARM) begin
        acnt_d = tick ? acnt_q + 1'b1 : acnt_q;
      end
    end
  end

  // State, prescaler and alarm counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SET;
      pre_q   <= '0;
      acnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      acnt_q  <= acnt_d;
    end
  end

  // Registered outputs, decoded from the next state so they track it one cycle after the cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      clken_q   <= 1'b0;
      min_inc_q <= 1'b0;
      sec_inc_q <= 1'b0;
      buzzer_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      mode_q    <= (state_d != ST_SET);
      clken_q   <= (state_d == ST_RUN);
      running_q <= (state_d == ST_RUN);
      buzzer_q  <= (state_d == ST_ALARM);
      min_inc_q <= min_inc_d;
      sec_inc_q <= sec_inc_d;
    end
  end

  assign bus.mode    = mode_q;
  assign bus.clken   = clken_q;
  assign bus.min_inc = min_inc_q;
  assign bus.sec_inc = sec_inc_q;
  assign bus.buzzer  = buzzer_q;
  assign bus.running = running_q;
endmodule

// File: tb/tb_m_timer_controller.sv
// Scoreboard bench for m_timer_controller: scenario code predicts every output
// change (cycle and value) into a queue; a monitor pops on each observed change.
module tb_m_timer_controller;
  localparam int DIV = 10;
  localparam int DB  = 4;
  localparam int AT  = 3;
  localparam int PL  = DB + 3;  // raw button edge (driven at a negedge) to output change

  typedef enum {M_SET, M_RUN, M_PAUSE, M_ALARM} mst_e;
  typedef struct {
    int         t;
    logic [5:0] v;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  ev_t  expq[$];
  ev_t  mon_e;
  logic [5:0] cur, prev;

  m_timer_controller_if bus ();

  m_timer_controller #(.DIV(DIV), .DEBOUNCE(DB), .ALARM_TICKS(AT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {mode, clken, running, buzzer, min_inc, sec_inc}
  assign cur = {bus.mode, bus.clken, bus.running, bus.buzzer, bus.min_inc, bus.sec_inc};

  function automatic logic [5:0] lvl(mst_e s);
    case (s)
      M_RUN:   return 6'b111000;
      M_PAUSE: return 6'b100000;
      M_ALARM: return 6'b100100;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic void expect_at(int t, logic [5:0] v);
    ev_t e;
    e.t = t;
    e.v = v;
    expq.push_back(e);
  endfunction

  function automatic void strobe(int t, mst_e s, bit is_min);
    expect_at(t, lvl(s) | (is_min ? 6'b000010 : 6'b000001));
    expect_at(t + 1, lvl(s));
  endfunction

  function automatic int hold_len();
    return DB + int'($urandom_range(0, 3));
  endfunction

  // Monitor: every change of the output vector must match the next predicted event.
  always @(negedge clk) begin
    if (mon_en && (cur !== prev)) begin
      n_tests++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change from %b", cyc, cur, prev);
      end else begin
        mon_e = expq.pop_front();
        if ((mon_e.t != cyc) || (mon_e.v !== cur)) begin
          n_fail++;
          $display("FAIL event got cyc=%0d val=%b required cyc=%0d val=%b", cyc, cur, mon_e.t, mon_e.v);
        end
      end
      prev = cur;
    end
  end

  task automatic tick_to(int t);
    if (cyc > t) begin
      n_fail++;
      $display("FAIL schedule got cyc=%0d required cyc<=%0d", cyc, t);
    end
    while (cyc < t) @(negedge clk);
  endtask

  // m = {start, min, sec}; returns the cycle at which the press takes effect.
  task automatic raise(input logic [2:0] m, output int pc);
    bus.btn_start = m[2];
    bus.btn_min   = m[1];
    bus.btn_sec   = m[0];
    pc = cyc + PL;
  endtask

  task automatic release_after(input int pc, input int hold);
    tick_to(pc - PL + hold);
    bus.btn_start = 1'b0;
    bus.btn_min   = 1'b0;
    bus.btn_sec   = 1'b0;
    tick_to(pc - PL + hold + DB + 4);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog got cyc=%0d required completion", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int pc, pc2, pc3, pc4, pc5, a, z, n, off, rem_s, rem_m;
    bit is_min;
    logic [2:0] m;

    bus.btn_min = 1'b0; bus.btn_sec = 1'b0; bus.btn_start = 1'b0; bus.cnt_zero = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cur !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_state got=%b required=000000", cur);
    end
    prev = 6'b000000;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // Glitches shorter than the debounce window must produce nothing.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) bus.btn_min = 1'b1; else bus.btn_sec = 1'b1;
      repeat ($urandom_range(1, DB - 1)) @(negedge clk);
      bus.btn_min = 1'b0; bus.btn_sec = 1'b0;
      repeat (DB + 6) @(negedge clk);
    end

    // SET phase: mixed sec/min presses in random order.
    rem_s = int'($urandom_range(2, 3));
    rem_m = int'($urandom_range(1, 2));
    while (rem_s + rem_m > 0) begin
      is_min = (rem_m > 0) && ((rem_s == 0) || ($urandom_range(0, 1) == 1));
      if (is_min) rem_m--; else rem_s--;
      raise(is_min ? 3'b010 : 3'b001, pc);
      strobe(pc, M_SET, is_min);
      release_after(pc, hold_len());
    end

    // Countdown, then cnt_zero (possibly on a tick cycle) and natural alarm expiry.
    raise(3'b100, pc);
    expect_at(pc, lvl(M_RUN));
    release_after(pc, hold_len());
    n = int'($urandom_range(1, 3));
    for (int k = 1; k <= n; k++) strobe(pc + DIV * k, M_RUN, 1'b0);
    z = pc + DIV * n + int'($urandom_range(2, 9));
    tick_to(z);
    bus.cnt_zero = 1'b1;
    a = z + 1;
    expect_at(a, lvl(M_ALARM));
    expect_at(a + AT * DIV, lvl(M_SET));
    tick_to(a + AT * DIV + 3);

    // Start while the chain reads zero is ignored.
    raise(3'b100, pc);
    release_after(pc, hold_len());
    bus.cnt_zero = 1'b0;
    repeat (3) @(negedge clk);

    // Pause exactly on a tick, resume, pause again, then leave PAUSE with min/sec.
    raise(3'b100, pc);
    expect_at(pc, lvl(M_RUN));
    release_after(pc, hold_len());
    n = int'($urandom_range(2, 3));
    for (int k = 1; k <= n; k++) strobe(pc + DIV * k, M_RUN, 1'b0);
    pc2 = pc + DIV * (n + 1);
    tick_to(pc2 - PL);
    raise(3'b100, pc);
    expect_at(pc2, lvl(M_PAUSE));
    release_after(pc2, hold_len());
    tick_to(pc2 + 8 + int'($urandom_range(0, 10)));
    raise(3'b100, pc3);
    expect_at(pc3, lvl(M_RUN));
    release_after(pc3, hold_len());
    n = int'($urandom_range(2, 3));
    for (int k = 1; k <= n; k++) strobe(pc3 + DIV * k, M_RUN, 1'b0);
    pc4 = pc3 + DIV * n + int'($urandom_range(2, 9));
    tick_to(pc4 - PL);
    raise(3'b100, pc);
    expect_at(pc4, lvl(M_PAUSE));
    release_after(pc4, hold_len());
    raise(($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001, pc5);
    expect_at(pc5, lvl(M_SET));
    release_after(pc5, hold_len());

    // Start and min together, then abort the alarm with a random press.
    raise(3'b110, pc);
    expect_at(pc, lvl(M_RUN));
    release_after(pc, hold_len());
    strobe(pc + DIV, M_RUN, 1'b0);
    z = pc + DIV + int'($urandom_range(2, 9));
    tick_to(z);
    bus.cnt_zero = 1'b1;
    a = z + 1;
    expect_at(a, lvl(M_ALARM));
    pc2 = a + int'($urandom_range(8, AT * DIV - 1));
    tick_to(pc2 - PL);
    m = 3'($urandom_range(1, 7));
    raise(m, pc);
    expect_at(pc2, lvl(M_SET));
    release_after(pc2, hold_len());
    bus.cnt_zero = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-RUN with min held through it: no press afterwards, then a clean press.
    raise(3'b100, pc);
    expect_at(pc, lvl(M_RUN));
    release_after(pc, hold_len());
    strobe(pc + DIV, M_RUN, 1'b0);
    tick_to(pc + DIV + 3);
    bus.btn_min = 1'b1;
    #1 rst_n = 1'b0;
    expect_at(cyc + 1, lvl(M_SET));
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (DB + 6) @(negedge clk);
    bus.btn_min = 1'b0;
    repeat (DB + 6) @(negedge clk);
    raise(3'b010, pc);
    strobe(pc, M_SET, 1'b1);
    release_after(pc, hold_len());
    raise(3'b001, pc);
    strobe(pc, M_SET, 1'b0);
    release_after(pc, hold_len());

    repeat (10) @(negedge clk);
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events got=%0d outstanding required=0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
